// File: rtl/mips_alu_32_if.sv
// Operand/result bundle for the execute-stage ALU.
// The datapath side drives operands and the control code. The ALU drives the
// registered result and status flags back.
interface mips_alu_32_if;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic [3:0]  control;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        err_overflow;
  logic        err_invalid_control;

  // Operand source (datapath / testbench)
  modport master (
    output input_a, input_b, control,
    input  result, zero, cout, err_overflow, err_invalid_control
  );

  // ALU side
  modport slave (
    input  input_a, input_b, control,
    output result, zero, cout, err_overflow, err_invalid_control
  );
endinterface

// File: rtl/mips_alu_32.sv
// 32-bit registered MIPS execute-stage ALU.
// The combinational datapath computes AND/OR/NOR, signed and unsigned add,
// subtract and signed set-less-than, plus carry, overflow and zero flags.
// A single output register bank captures everything on the rising clock edge.
// Latency is one cycle, and a new operation is accepted every cycle.
module mips_alu_32 (
  input  logic          clock,
  input  logic          reset_n,
  mips_alu_32_if.slave  bus
);

  // Control encodings; benches may reference these hierarchically.
  localparam logic [3:0] CONTROL_AND          = 4'b0000;
  localparam logic [3:0] CONTROL_OR           = 4'b0001;
  localparam logic [3:0] CONTROL_ADD          = 4'b0010;
  localparam logic [3:0] CONTROL_ADD_UNSIGNED = 4'b0011;
  localparam logic [3:0] CONTROL_SUB          = 4'b0110;
  localparam logic [3:0] CONTROL_SLT          = 4'b0111;
  localparam logic [3:0] CONTROL_NOR          = 4'b1100;

  logic [31:0] a;
  logic [31:0] b;

  // 33-bit sums; bit 32 is the carry out of bit 31.
  logic [32:0] add_full;
  logic [32:0] sub_full;
  logic        add_ovf;
  logic        sub_ovf;
  logic        slt_lt;

  // Next-state values for the output register bank.
  logic [31:0] result_d;
  logic        zero_d;
  logic        cout_d;
  logic        ovf_d;
  logic        inv_d;

  // Registered outputs.
  logic [31:0] result_q;
  logic        zero_q;
  logic        cout_q;
  logic        ovf_q;
  logic        inv_q;

  assign a = bus.input_a;
  assign b = bus.input_b;

  // Shared adder paths: a+b, and a+~b+1 for subtract and set-less-than.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + 33'd1;
    add_ovf  = (a[31] == b[31]) && (add_full[31] != a[31]);
    sub_ovf  = (a[31] != b[31]) && (sub_full[31] != a[31]);
    // The sign of a-b is wrong exactly when the subtract overflowed, so the
    // XOR with the overflow bit gives a correct result at the extremes.
    slt_lt   = sub_full[31] ^ sub_ovf;
  end

  // Operation select and flag generation.
  always_comb begin
    // NOTE: every output gets a default before the case. A path that leaves a
    // signal unassigned in combinational logic would infer a latch.
    result_d = 32'd0;
    cout_d   = 1'b0;
    ovf_d    = 1'b0;
    inv_d    = 1'b0;
    unique case (bus.control)
      CONTROL_AND: result_d = a & b;
      CONTROL_OR:  result_d = a | b;
      CONTROL_NOR: result_d = ~(a | b);
      CONTROL_ADD_UNSIGNED: begin
        result_d = add_full[31:0];
        cout_d   = add_full[32];
      end
      CONTROL_ADD: begin
        result_d = add_full[31:0];
        cout_d   = add_full[32];
        ovf_d    = add_ovf;
      end
      CONTROL_SUB: begin
        // cout=1 means no borrow occurred.
        result_d = sub_full[31:0];
        cout_d   = sub_full[32];
        ovf_d    = sub_ovf;
      end
      CONTROL_SLT: result_d = {31'd0, slt_lt};
      default:     inv_d    = 1'b1;
    endcase
    // An invalid code is never reported as a zero result.
    zero_d = !inv_d && (result_d == 32'd0);
  end

  // Output register bank; async reset clears all outputs immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. All registers update together from
      // values computed before the edge, so the result does not depend on
      // the order of the statements.
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
    end
  end

  assign bus.result              = result_q;
  assign bus.zero                = zero_q;
  assign bus.cout                = cout_q;
  assign bus.err_overflow        = ovf_q;
  assign bus.err_invalid_control = inv_q;

endmodule

// File: tb/tb_mips_alu_32.sv
// Directed self-checking bench for mips_alu_32.
// Every vector carries hand-computed expected outputs. Outputs are sampled
// 1 time unit after the capturing rising edge, and inputs are driven on the
// falling edge.
module tb_mips_alu_32;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_ADDU = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_NOR  = 4'b1100;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  mips_alu_32_if bus ();

  mips_alu_32 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] res, input logic z,
                           input logic c, input logic v, input logic inv);
    check({tag, ".result"},  bus.result, res);
    check({tag, ".zero"},    {31'd0, bus.zero}, {31'd0, z});
    check({tag, ".cout"},    {31'd0, bus.cout}, {31'd0, c});
    check({tag, ".ovf"},     {31'd0, bus.err_overflow}, {31'd0, v});
    check({tag, ".inv"},     {31'd0, bus.err_invalid_control}, {31'd0, inv});
  endtask

  // Drive one operation, let it be captured, then check the registered outputs.
  task automatic op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res, input logic z,
                    input logic c, input logic v, input logic inv);
    @(negedge clock);
    bus.control = ctrl;
    bus.input_a = a;
    bus.input_b = b;
    @(posedge clock);
    #1;
    check_all(tag, res, z, c, v, inv);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset_n     = 1'b0;
    bus.control = C_ADDU;
    bus.input_a = 32'hFFFF_FFFF;
    bus.input_b = 32'h0000_0001;

    // Reset state, including across a clock edge with reset still low.
    #2;
    check_all("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_all("reset_held", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Logic operations.
    op("and_zero", C_AND, 32'h0000_FF00, 32'h0000_00FF, 32'h0000_0000, 1, 0, 0, 0);
    op("and_mask", C_AND, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_000F, 0, 0, 0, 0);
    op("or",       C_OR,  32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0, 0, 0, 0);
    op("nor",      C_NOR, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0, 0);
    op("nor_zero", C_NOR, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_0000, 1, 0, 0, 0);

    // Unsigned add: carry reported, overflow never flagged.
    op("addu_wrap", C_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0);
    op("addu_dec",  C_ADDU, 32'd1234,      32'd4321,      32'd5555,      0, 0, 0, 0);
    op("addu_sgn",  C_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 0, 0);

    // Signed add.
    op("add_posovf", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0);
    op("add_negovf", C_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 1, 1, 0);
    op("add_m1p1",   C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0);

    // Subtract: cout=1 means no borrow.
    op("sub_ovf",    C_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1, 0);
    op("sub_borrow", C_SUB, 32'd100,       32'd101,       32'hFFFF_FFFF, 0, 0, 0, 0);
    op("sub_zero",   C_SUB, 32'd1,         32'd1,         32'h0000_0000, 1, 1, 0, 0);

    // Signed set-less-than, including the overflow extreme.
    op("slt_neg",  C_SLT, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0);
    op("slt_zm1",  C_SLT, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 0);
    op("slt_ext",  C_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 0);
    op("slt_extr", C_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 0);

    // Invalid codes: everything cleared except err_invalid_control.
    op("inv_f", 4'hF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 0, 0, 1);
    op("inv_4", 4'h4, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 1);

    // Async reset mid-stream: load nonzero outputs, then pulse reset between edges.
    op("pre_rst", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0);
    op("pre_rst2", C_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("rst_async", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_all("rst_low_edge", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Operation after reset release.
    op("post_rst", C_SUB, 32'd5, 32'd3, 32'd2, 0, 1, 0, 0);
    // Back-to-back throughput with an invalid code followed by a valid one.
    op("b2b_inv", 4'hE, 32'd5, 32'd5, 32'd0, 0, 0, 0, 1);
    op("b2b_and", C_AND, 32'd5, 32'd5, 32'd5, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
